pipe_stage_reg: RTL and testbench

Parametrised elastic pipeline register for the five-stage core. It replaces the fixed-field, always-enabled stage registers between F/D/E/M/W with one reusable block. The block carries a generic data bus and a control bus and adds a valid/ready handshake, an optional skid slot, stall and flush. Control bits are forced to zero whenever the stage holds a bubble, so a flushed or empty stage can never assert register or memory write enables downstream.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_stage_reg.sv | 154 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the elastic pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_BUSY,
        ST_FULL
    } pipe_state_e;

    localparam int unsigned PIPE_DATA_W = 32;
    localparam int unsigned PIPE_CTRL_W = 8;

endpackage

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register with valid/ready handshake, optional skid slot, flush,
// and a control bus that is held at zero whenever the stage holds a bubble.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = PIPE_DATA_W,
    parameter int unsigned CTRL_W = PIPE_CTRL_W,
    parameter int unsigned SKID   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [1:0]        o_count
);

    if (SKID != 0) begin : g_skid
        pipe_state_e       state_q, state_d;
        logic              ready_q;
        logic [DATA_W-1:0] main_data_q, skid_data_q;
        logic [CTRL_W-1:0] main_ctrl_q, skid_ctrl_q;
        logic              in_fire, out_fire;
        logic              main_ld, skid_ld, main_from_skid;

        assign in_fire  = i_valid & ready_q;
        assign out_fire = (state_q != ST_EMPTY) & i_ready;

        always_comb begin
            state_d        = state_q;
            main_ld        = 1'b0;
            skid_ld        = 1'b0;
            main_from_skid = 1'b0;
            if (i_flush) begin
                state_d = ST_EMPTY;
            end else begin
                unique case (state_q)
                    ST_EMPTY: begin
                        if (in_fire) begin
                            main_ld = 1'b1;
                            state_d = ST_BUSY;
                        end
                    end
                    ST_BUSY: begin
                        if (in_fire && out_fire) begin
                            main_ld = 1'b1;
                        end else if (in_fire) begin
                            skid_ld = 1'b1;
                            state_d = ST_FULL;
                        end else if (out_fire) begin
                            state_d = ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (out_fire) begin
                            main_from_skid = 1'b1;
                            state_d        = ST_BUSY;
                        end
                    end
                    default: state_d = ST_EMPTY;
                endcase
            end
        end

        // o_ready is registered so upstream never sees a path from i_ready.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                state_q     <= ST_EMPTY;
                ready_q     <= 1'b1;
                main_data_q <= '0;
                main_ctrl_q <= '0;
                skid_data_q <= '0;
                skid_ctrl_q <= '0;
            end else begin
                state_q <= state_d;
                ready_q <= (state_d != ST_FULL);
                if (main_ld) begin
                    main_data_q <= i_data;
                end else if (main_from_skid) begin
                    main_data_q <= skid_data_q;
                end
                if (state_d == ST_EMPTY) begin
                    main_ctrl_q <= '0;
                end else if (main_ld) begin
                    main_ctrl_q <= i_ctrl;
                end else if (main_from_skid) begin
                    main_ctrl_q <= skid_ctrl_q;
                end
                if (skid_ld) begin
                    skid_data_q <= i_data;
                    skid_ctrl_q <= i_ctrl;
                end
            end
        end

        assign o_ready = ready_q;
        assign o_valid = (state_q != ST_EMPTY);
        assign o_data  = main_data_q;
        assign o_ctrl  = main_ctrl_q;
        assign o_count = (state_q == ST_FULL) ? 2'd2 :
                         (state_q == ST_BUSY) ? 2'd1 : 2'd0;
    end else begin : g_noskid
        logic              valid_q, valid_d;
        logic [DATA_W-1:0] data_q;
        logic [CTRL_W-1:0] ctrl_q;
        logic              ready, in_fire, out_fire;

        assign ready    = i_ready | ~valid_q;
        assign in_fire  = i_valid & ready;
        assign out_fire = valid_q & i_ready;

        always_comb begin
            valid_d = valid_q;
            if (i_flush) begin
                valid_d = 1'b0;
            end else if (in_fire) begin
                valid_d = 1'b1;
            end else if (out_fire) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                valid_q <= 1'b0;
                data_q  <= '0;
                ctrl_q  <= '0;
            end else begin
                valid_q <= valid_d;
                if (!i_flush && in_fire) begin
                    data_q <= i_data;
                end
                if (!valid_d) begin
                    ctrl_q <= '0;
                end else if (!i_flush && in_fire) begin
                    ctrl_q <= i_ctrl;
                end
            end
        end

        assign o_ready = ready;
        assign o_valid = valid_q;
        assign o_data  = data_q;
        assign o_ctrl  = ctrl_q;
        assign o_count = {1'b0, valid_q};
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance share stimulus,
// each checked against a queue model of the entries it should be holding.
module tb_pipe_stage_reg;

    typedef logic [39:0] beat_t;  // {ctrl, data}

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_ready;

    logic        s1_ready, s1_valid, s0_ready, s0_valid;
    logic [31:0] s1_data, s0_data;
    logic [7:0]  s1_ctrl, s0_ctrl;
    logic [1:0]  s1_count, s0_count;

    int checks   = 0;
    int failures = 0;

    beat_t       m1[$], m0[$], sb1[$], sb0[$];
    logic [31:0] last1, last0;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(1)) u_skid (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid),
        .o_ready(s1_ready), .i_data(in_data), .i_ctrl(in_ctrl), .o_valid(s1_valid),
        .i_ready(out_ready), .o_data(s1_data), .o_ctrl(s1_ctrl), .o_count(s1_count)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(8), .SKID(0)) u_noskid (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid),
        .o_ready(s0_ready), .i_data(in_data), .i_ctrl(in_ctrl), .o_valid(s0_valid),
        .i_ready(out_ready), .o_data(s0_data), .o_ctrl(s0_ctrl), .o_count(s0_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s1_valid"}, 64'(s1_valid), 64'(0));
        chk({tag, "_s1_ctrl"},  64'(s1_ctrl),  64'(0));
        chk({tag, "_s1_ready"}, 64'(s1_ready), 64'(1));
        chk({tag, "_s1_count"}, 64'(s1_count), 64'(0));
        chk({tag, "_s1_data"},  64'(s1_data),  64'(0));
        chk({tag, "_s0_valid"}, 64'(s0_valid), 64'(0));
        chk({tag, "_s0_ready"}, 64'(s0_ready), 64'(1));
        chk({tag, "_s0_count"}, 64'(s0_count), 64'(0));
    endtask

    // One cycle: drive at negedge, check state against model, log expected outputs, update model.
    task automatic step(input logic v, input logic [31:0] d, input logic [7:0] c,
                        input logic r, input logic f);
        logic rdy1, rdy0, out1, out0;
        @(negedge clk);
        rst_n = 1'b1; in_valid = v; in_data = d; in_ctrl = c; out_ready = r; flush = f;
        #2;
        rdy1 = (m1.size() < 2);
        rdy0 = r | (m0.size() == 0);
        out1 = (m1.size() != 0) && r;
        out0 = (m0.size() != 0) && r;

        chk("s1_count", 64'(s1_count), 64'(m1.size()));
        chk("s1_ready", 64'(s1_ready), 64'(rdy1));
        chk("s1_valid", 64'(s1_valid), 64'(m1.size() != 0));
        if (m1.size() != 0) begin
            chk("s1_head", 64'({s1_ctrl, s1_data}), 64'(m1[0]));
            last1 = m1[0][31:0];
        end else begin
            chk("s1_bubble_ctrl", 64'(s1_ctrl), 64'(0));
            chk("s1_data_hold", 64'(s1_data), 64'(last1));
        end

        chk("s0_count", 64'(s0_count), 64'(m0.size()));
        chk("s0_ready", 64'(s0_ready), 64'(rdy0));
        chk("s0_valid", 64'(s0_valid), 64'(m0.size() != 0));
        if (m0.size() != 0) begin
            chk("s0_head", 64'({s0_ctrl, s0_data}), 64'(m0[0]));
            last0 = m0[0][31:0];
        end else begin
            chk("s0_bubble_ctrl", 64'(s0_ctrl), 64'(0));
            chk("s0_data_hold", 64'(s0_data), 64'(last0));
        end

        if (out1) sb1.push_back(m1[0]);
        if (out0) sb0.push_back(m0[0]);

        @(posedge clk);
        if (out1) m1.delete(0);
        if (out0) m0.delete(0);
        if (f) begin
            m1.delete();
            m0.delete();
        end else begin
            if (v && rdy1) m1.push_back({c, d});
            if (v && rdy0) m0.push_back({c, d});
        end
    endtask

    // Monitor: pops an expected beat whenever a DUT presents an output fire.
    initial begin
        beat_t exp;
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && s1_valid && out_ready) begin
                if (sb1.size() == 0) begin
                    chk("s1_unexpected_beat", 64'({s1_ctrl, s1_data}), 64'(0));
                end else begin
                    exp = sb1.pop_front();
                    chk("s1_out", 64'({s1_ctrl, s1_data}), 64'(exp));
                end
            end
            if (rst_n && s0_valid && out_ready) begin
                if (sb0.size() == 0) begin
                    chk("s0_unexpected_beat", 64'({s0_ctrl, s0_data}), 64'(0));
                end else begin
                    exp = sb0.pop_front();
                    chk("s0_out", 64'({s0_ctrl, s0_data}), 64'(exp));
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1;
        in_data = 32'hDEADBEEF; in_ctrl = 8'h5A; out_ready = 1'b0;
        last1 = '0; last0 = '0;
        repeat (2) @(negedge clk);
        #2;
        chk_reset_outputs("reset");

        // First beat accepted on the first edge after release.
        step(1'b1, 32'hDEADBEEF, 8'h5A, 1'b0, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        for (int i = 1; i <= 8; i++) step(1'b1, 32'(i), 8'(i), 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // Backpressure fills the skid slot.
        step(1'b1, 32'hA, 8'h11, 1'b0, 1'b0);
        step(1'b1, 32'hB, 8'h22, 1'b0, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // Flush a full stage while a beat is offered.
        step(1'b1, 32'h1, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 32'h2, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 32'hC, 8'hFF, 1'b0, 1'b1);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // Flush coinciding with an output fire.
        step(1'b1, 32'h3, 8'h33, 1'b0, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b1);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // i_ready toggling 1,0,1 with two offered beats.
        step(1'b1, 32'h1, 8'h01, 1'b1, 1'b0);
        step(1'b1, 32'h2, 8'h02, 1'b0, 1'b0);
        step(1'b1, 32'h2, 8'h02, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        // Reset in mid-operation drops everything immediately.
        step(1'b1, 32'h77, 8'h77, 1'b0, 1'b0);
        step(1'b1, 32'h78, 8'h78, 1'b0, 1'b0);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        m1.delete(); m0.delete();
        last1 = '0; last0 = '0;
        @(posedge clk);

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 9) < 7, $urandom, 8'($urandom),
                 $urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 8'h00, 1'b1, 1'b0);

        @(negedge clk);
        #4;
        chk("s1_sb_drained", 64'(sb1.size()), 64'(0));
        chk("s0_sb_drained", 64'(sb0.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
